odo_round_engine: RTL and testbench
===================================

Name: odo_round_engine

Overview:
- Parametrised, iterative successor to the fixed four-round Odo encrypt loop.
- Accepts one WORDS×32-bit block over a valid/ready handshake, applies a pre-mix, then a runtime-selectable number of rounds (one round per clock), and holds the result on a valid/ready output.
- Sits between the miner's header/nonce feeder and the hash back-end.
- Generalises state width (WORDS), round count (runtime, clamped to ROUNDS_MAX) and rotation amount.

Parameters:
- WORDS, 20, number of 32-bit state words (≥2); DW = 32*WORDS.
- ROUNDS_MAX, 84, maximum rounds per block; RW = $clog2(ROUNDS_MAX+1).
- ROT, 8, left-rotate amount per word per round (1..31).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- in_valid  in  1  input block offered.
- in_ready  out  1  engine can accept; 0 while rst_n low.
- in_data  in  DW  block; word i = in_data[32*i+31:32*i].
- in_key  in  32  round key, latched on accept.
- in_rounds  in  RW  requested rounds, latched on accept.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes result.
- out_data  out  DW  result block.
- busy  out  1  1 in ROUND or DONE.
- blocks_done  out  32  count of results consumed, wraps 2^32-1→0.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; state, key, rcnt, rlim, out_data, blocks_done cleared to 0; out_valid=0; busy=0; in_ready=0. Applies mid-operation: in-flight block discarded, no output.
- Accept = in_valid && in_ready at a rising edge. in_ready = (FSM==IDLE) || (FSM==DONE && out_ready); combinational from out_ready is permitted.
- Pre-mix on accept: T = XOR of all words; state[i] <= in_data word i ^ T. Latch key, rcnt <= 0, rlim <= min(in_rounds, ROUNDS_MAX).
- Round r (0-based), from words w:
  - t[i] = rotl(w[i], ROT) ^ w[(i+1) mod WORDS];
  - then t[0] ^= key ^ zero-extended r.
- FSM:
  - IDLE: on accept, go to ROUND if rlim≠0, else to DONE.
  - ROUND: each cycle state <= round(state, rcnt) and rcnt++. After the round with rcnt==rlim-1, go to DONE.
  - DONE: out_valid=1, out_data=state. Hold stable while out_ready=0. On out_ready=1: blocks_done++, then go to IDLE, or to ROUND/DONE if an accept happens in the same cycle (back-to-back, no bubble).
- Latency: out_valid first high R+1 cycles after the accept cycle (R = clamped rounds). Throughput is one block per R+1 cycles.
- in_valid/in_data are ignored when not accepted. in_rounds > ROUNDS_MAX is clamped, not an error.
- out_data holds its last value after consume until overwritten by the next DONE entry. Only out_valid qualifies it.
- All arithmetic is mod 2^32 per word. Rotation is per 32-bit word; there is no cross-word carry.

Test Plan:
1. WORDS=4, ROT=8. Reset, then offer w0=1, w1..w3=0, key=0, rounds=0 → out_valid 1 cycle after accept; out_data words {w0..w3} = {0,1,1,1}; blocks_done=1 after consume.
2. Same block, rounds=1, key=0 → out words {0x1, 0x101, 0x101, 0x100}; latency 2 cycles.
3. Zero block, key=0x5, rounds=2 → out words {0x504, 0, 0, 0x5}; latency 3 cycles; busy high for 3 cycles.
4. Backpressure: after case 3, hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0; then assert out_ready with in_valid=1 and a new block → accepted the same cycle, blocks_done increments, the next result follows with no idle cycle.
5. Clamp: WORDS=20 defaults, in_rounds=127 → out_valid exactly 85 cycles after accept.
6. Reset mid-round: pull rst_n low during ROUND (rcnt=1 of 5) → out_valid, busy and in_ready drop immediately; out_data=0 and blocks_done=0; after release, in_ready=1 on the next cycle and a fresh block completes correctly.

Source files
------------

// File: rtl/odo_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : odo_round_engine
//  Purpose  : Iterative Odo round engine. Accepts one WORDS x 32-bit block on
//             a valid/ready input, applies an XOR-fold pre-mix, runs a
//             runtime-selected number of rounds (one per clock, clamped to
//             ROUNDS_MAX) and presents the result on a valid/ready output.
//
//  Ports    : clk          clock, all state on rising edge
//             rst_n        asynchronous active-low reset
//             in_valid     input block offered
//             in_ready     engine can accept (0 while rst_n low)
//             in_data      block, word i = in_data[32*i +: 32]
//             in_key       round key, latched on accept
//             in_rounds    requested rounds, latched on accept (clamped)
//             out_valid    result available
//             out_ready    downstream consumes result
//             out_data     result block (qualified by out_valid only)
//             busy         engine is in ROUND or DONE
//             blocks_done  count of consumed results, wraps at 2^32
//
//  Revision : 1.0  initial release
// ============================================================================
module odo_round_engine #(
    parameter int WORDS      = 20,
    parameter int ROUNDS_MAX = 84,
    parameter int ROT        = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [32*WORDS-1:0]               in_data,
    input  logic [31:0]                       in_key,
    input  logic [$clog2(ROUNDS_MAX+1)-1:0]   in_rounds,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [32*WORDS-1:0]               out_data,
    output logic                              busy,
    output logic [31:0]                       blocks_done
);

    localparam int c_DW = 32 * WORDS;
    localparam int c_RW = $clog2(ROUNDS_MAX + 1);

    localparam logic [c_RW-1:0] c_ROUNDS_MAX = c_RW'(ROUNDS_MAX);
    localparam logic [c_RW-1:0] c_ONE        = c_RW'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ROUND = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]      r_fsm;
    logic [c_DW-1:0] r_state;
    logic [31:0]     r_key;
    logic [c_RW-1:0] r_rcnt;
    logic [c_RW-1:0] r_rlim;
    logic [c_DW-1:0] r_out_data;
    logic [31:0]     r_blocks_done;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last_round;
    logic [c_RW-1:0] w_rlim_in;
    logic [31:0]     w_fold;
    logic [c_DW-1:0] w_premix;
    logic [c_DW-1:0] w_round;

    // Ready is gated by rst_n so nothing can be offered into a held reset.
    // The DONE term lets a new block enter in the same cycle the old result
    // leaves, so back-to-back blocks run without a bubble.
    assign w_in_ready   = rst_n && ((r_fsm == c_S_IDLE) ||
                                    ((r_fsm == c_S_DONE) && out_ready));
    assign w_accept     = in_valid && w_in_ready;
    assign w_rlim_in    = (in_rounds > c_ROUNDS_MAX) ? c_ROUNDS_MAX : in_rounds;
    assign w_last_round = (r_rcnt == (r_rlim - c_ONE));

    // Pre-mix: every word is XORed with the XOR of all words.
    always_comb begin
        w_fold   = '0;
        w_premix = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_fold = w_fold ^ in_data[32*i +: 32];
        end
        for (int i = 0; i < WORDS; i++) begin
            w_premix[32*i +: 32] = in_data[32*i +: 32] ^ w_fold;
        end
    end

    // One round: rotate each word left and mix in its upper neighbour
    // (wrapping); word 0 also absorbs the key and the round index.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        localparam int c_NXT = (gi + 1) % WORDS;
        logic [31:0] w_cur;
        logic [31:0] w_rot;
        logic [31:0] w_mix;
        assign w_cur = r_state[32*gi +: 32];
        assign w_rot = (w_cur << ROT) | (w_cur >> (32 - ROT));
        assign w_mix = w_rot ^ r_state[32*c_NXT +: 32];
        if (gi == 0) begin : g_first
            assign w_round[31:0] = w_mix ^ r_key ^ 32'(r_rcnt);
        end else begin : g_rest
            assign w_round[32*gi +: 32] = w_mix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm         <= c_S_IDLE;
            r_state       <= '0;
            r_key         <= '0;
            r_rcnt        <= '0;
            r_rlim        <= '0;
            r_out_data    <= '0;
            r_blocks_done <= '0;
        end else begin
            if ((r_fsm == c_S_DONE) && out_ready) begin
                r_blocks_done <= r_blocks_done + 32'd1;
            end

            // An accept can only occur in IDLE or in a consuming DONE cycle,
            // so it takes priority over the per-state behaviour below.
            if (w_accept) begin
                r_state <= w_premix;
                r_key   <= in_key;
                r_rcnt  <= '0;
                r_rlim  <= w_rlim_in;
                if (w_rlim_in == '0) begin
                    r_fsm      <= c_S_DONE;
                    r_out_data <= w_premix;
                end else begin
                    r_fsm      <= c_S_ROUND;
                end
            end else begin
                case (r_fsm)
                    c_S_IDLE: begin
                        r_fsm <= c_S_IDLE;
                    end
                    c_S_ROUND: begin
                        r_state <= w_round;
                        r_rcnt  <= r_rcnt + c_ONE;
                        if (w_last_round) begin
                            r_fsm      <= c_S_DONE;
                            r_out_data <= w_round;
                        end
                    end
                    c_S_DONE: begin
                        if (out_ready) begin
                            r_fsm <= c_S_IDLE;
                        end
                    end
                    default: begin
                        r_fsm <= c_S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_fsm == c_S_DONE);
    assign busy        = (r_fsm == c_S_ROUND) || (r_fsm == c_S_DONE);
    assign out_data    = r_out_data;
    assign blocks_done = r_blocks_done;

endmodule
`default_nettype wire

// File: tb/tb_odo_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odo_round_engine
//  Purpose  : Directed self-checking bench for odo_round_engine. A 4-word
//             instance covers data, latency, backpressure and reset; a
//             default 20-word instance covers round-count clamping.
//  Revision : 1.0  initial release
// ============================================================================
module tb_odo_round_engine;

    logic clk;
    logic rst_n;

    // 4-word instance
    logic         in_valid4;
    logic         in_ready4;
    logic [127:0] in_data4;
    logic [31:0]  in_key4;
    logic [6:0]   in_rounds4;
    logic         out_valid4;
    logic         out_ready4;
    logic [127:0] out_data4;
    logic         busy4;
    logic [31:0]  blocks_done4;

    // default 20-word instance
    logic         in_valid20;
    logic         in_ready20;
    logic [639:0] in_data20;
    logic [31:0]  in_key20;
    logic [6:0]   in_rounds20;
    logic         out_valid20;
    logic         out_ready20;
    logic [639:0] out_data20;
    logic         busy20;
    logic [31:0]  blocks_done20;

    int n_assert;
    int n_fail;
    int lat;

    localparam logic [127:0] c_RES1  = {32'h1, 32'h1, 32'h1, 32'h0};
    localparam logic [127:0] c_RES2  = {32'h100, 32'h101, 32'h101, 32'h1};
    localparam logic [127:0] c_RES3  = {32'h5, 32'h0, 32'h0, 32'h504};
    localparam logic [127:0] c_BLK1  = 128'h1;
    localparam logic [127:0] c_JUNK  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

    odo_round_engine #(.WORDS(4), .ROUNDS_MAX(84), .ROT(8)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .in_data     (in_data4),
        .in_key      (in_key4),
        .in_rounds   (in_rounds4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .out_data    (out_data4),
        .busy        (busy4),
        .blocks_done (blocks_done4)
    );

    odo_round_engine u_dut20 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid20),
        .in_ready    (in_ready20),
        .in_data     (in_data20),
        .in_key      (in_key20),
        .in_rounds   (in_rounds20),
        .out_valid   (out_valid20),
        .out_ready   (out_ready20),
        .out_data    (out_data20),
        .busy        (busy20),
        .blocks_done (blocks_done20)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [639:0] obs,
                         input logic [639:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge; returns the cycle index in which
    // out_valid is first seen (1 = the cycle right after accept).
    task automatic wait4(output int n);
        n = 1;
        while (!out_valid4 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic wait20(output int n);
        n = 1;
        while (!out_valid20 && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid4   = 1'b0;
        in_data4    = '0;
        in_key4     = '0;
        in_rounds4  = '0;
        out_ready4  = 1'b0;
        in_valid20  = 1'b0;
        in_data20   = '0;
        in_key20    = '0;
        in_rounds20 = '0;
        out_ready20 = 1'b0;

        // Reset state
        step();
        step();
        check("rst_out_valid", out_valid4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_in_ready", in_ready4, 1'b0);
        check("rst_out_data", out_data4, 128'h0);
        check("rst_blocks_done", blocks_done4, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready4, 1'b1);

        // 1: rounds=0, pre-mix only
        in_data4   = c_BLK1;
        in_key4    = 32'h0;
        in_rounds4 = 7'd0;
        in_valid4  = 1'b1;
        step();
        in_valid4 = 1'b0;
        wait4(lat);
        check("t1_latency", lat, 1);
        check("t1_data", out_data4, c_RES1);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("t1_blocks_done", blocks_done4, 32'd1);
        check("t1_out_valid_low", out_valid4, 1'b0);

        // 2: one round
        in_rounds4 = 7'd1;
        in_valid4  = 1'b1;
        step();
        in_valid4 = 1'b0;
        wait4(lat);
        check("t2_latency", lat, 2);
        check("t2_data", out_data4, c_RES2);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("t2_blocks_done", blocks_done4, 32'd2);

        // 3: zero block, key 5, two rounds; junk offered while busy
        in_data4   = '0;
        in_key4    = 32'h5;
        in_rounds4 = 7'd2;
        in_valid4  = 1'b1;
        step();
        in_data4   = c_JUNK;
        in_key4    = 32'hFFFF_FFFF;
        in_rounds4 = 7'd0;
        #1;
        check("t3_c1_busy", busy4, 1'b1);
        check("t3_c1_valid", out_valid4, 1'b0);
        check("t3_c1_in_ready", in_ready4, 1'b0);
        step();
        check("t3_c2_busy", busy4, 1'b1);
        check("t3_c2_valid", out_valid4, 1'b0);
        step();
        check("t3_c3_busy", busy4, 1'b1);
        check("t3_c3_valid", out_valid4, 1'b1);
        check("t3_data", out_data4, c_RES3);

        // 4: backpressure for 10 cycles, junk still offered
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_hold", {out_valid4, in_ready4, out_data4},
                  {1'b1, 1'b0, c_RES3});
        end
        check("t4_blocks_hold", blocks_done4, 32'd2);
        in_data4   = c_BLK1;
        in_key4    = 32'h0;
        in_rounds4 = 7'd1;
        out_ready4 = 1'b1;
        #1;
        check("t4_in_ready_on_consume", in_ready4, 1'b1);
        step();
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        check("t4_blocks_done", blocks_done4, 32'd3);
        check("t4_round_busy", busy4, 1'b1);
        check("t4_round_valid", out_valid4, 1'b0);
        step();
        check("t4_next_valid", out_valid4, 1'b1);
        check("t4_next_data", out_data4, c_RES2);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("t4_final_blocks", blocks_done4, 32'd4);
        check("t4_idle_busy", busy4, 1'b0);

        // 5: clamp 127 -> 84 rounds on the 20-word instance
        in_data20   = {20{32'h1357_9BDF}} ^ 640'h1234_5678;
        in_key20    = 32'hA5A5_0F0F;
        in_rounds20 = 7'd127;
        in_valid20  = 1'b1;
        step();
        in_valid20 = 1'b0;
        wait20(lat);
        check("t5_clamp_latency", lat, 85);
        out_ready20 = 1'b1;
        step();
        out_ready20 = 1'b0;
        check("t5_blocks_done", blocks_done20, 32'd1);

        // 6: asynchronous reset during ROUND with rcnt=1 of 5
        in_data4   = c_BLK1;
        in_key4    = 32'h0;
        in_rounds4 = 7'd5;
        in_valid4  = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        check("t6_busy_before", busy4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy_async", busy4, 1'b0);
        check("t6_valid_async", out_valid4, 1'b0);
        check("t6_in_ready_async", in_ready4, 1'b0);
        check("t6_out_data_async", out_data4, 128'h0);
        check("t6_blocks_async", blocks_done4, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_in_ready_after", in_ready4, 1'b1);
        check("t6_no_output", out_valid4, 1'b0);
        in_data4   = '0;
        in_key4    = 32'h5;
        in_rounds4 = 7'd2;
        in_valid4  = 1'b1;
        step();
        in_valid4 = 1'b0;
        wait4(lat);
        check("t6_fresh_latency", lat, 3);
        check("t6_fresh_data", out_data4, c_RES3);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("t6_fresh_blocks", blocks_done4, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
